conv_ctrl: RTL and testbench

Sequencing controller for the 3x3 PE array with its three inter-row async FIFOs. It receives a start command and a valid/ready raster pixel stream. It generates `set_wgt`, `set_ifm`, `set_reg`, `wr_en_0..2`, `rd_en_0..2`, `rd_clr` and `wr_clr`, and flags which FIFO-2 reads carry a valid convolution output. It sits beside the array in the `clk1` domain, between the input feature map source and the array control pins.

---
 rtl/conv_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_conv_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_ctrl.sv
//------------------------------------------------------------------------------
// conv_ctrl
//
// Sequencing controller for a KERNEL_SIZE x KERNEL_SIZE PE array and its three
// inter-row FIFOs. It accepts a raster pixel stream over valid/ready and drives
// the array load/advance strobes and the FIFO pointer controls. It also flags
// which FIFO-2 reads carry a valid convolution output.
//
// Ports
//   clk1       in   sole clock
//   rst        in   synchronous, active-high reset
//   start      in   begins a frame when IDLE, ignored otherwise
//   ifm_valid  in   pixel available upstream
//   ifm_ready  out  controller accepts a pixel (STREAM only)
//   set_wgt    out  weight buffer load strobe
//   set_ifm    out  IFM buffer load strobe (one per accepted pixel)
//   set_reg    out  PE advance strobe
//   wr_en[2:0] out  FIFO k write enable
//   rd_en[2:0] out  FIFO k read enable
//   rd_clr     out  FIFO read-pointer clear
//   wr_clr     out  FIFO write-pointer clear
//   out_valid  out  the FIFO-2 read in this cycle is a valid conv result
//   busy       out  high in every state except IDLE
//   done       out  one-cycle end-of-frame pulse
//   stall_cnt  out  STREAM cycles spent with ifm_valid low
//
// Build option
//   CONV_CTRL_STALL_CNT_EN  enables the saturating stall counter. When it is
//                           left undefined, stall_cnt is tied to zero.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module conv_ctrl #(
    parameter int IFM_W       = 8,
    parameter int IFM_H       = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int FIFO_SIZE   = 7,
    parameter int CNT_WIDTH   = 8
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        start,
    input  logic        ifm_valid,
    output logic        ifm_ready,
    output logic        set_wgt,
    output logic        set_ifm,
    output logic        set_reg,
    output logic [2:0]  wr_en,
    output logic [2:0]  rd_en,
    output logic        rd_clr,
    output logic        wr_clr,
    output logic        out_valid,
    output logic        busy,
    output logic        done,
    output logic [15:0] stall_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLEAR    = 3'd1;
    localparam logic [2:0] S_LOAD_WGT = 3'd2;
    localparam logic [2:0] S_STREAM   = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    // Occupancy at which FIFOs 0/1 start being read. The value is clamped to
    // the FIFO depth so that a mis-parameterised build cannot overfill a FIFO.
    localparam int LP_RD_THR_I = (IFM_W - KERNEL_SIZE < FIFO_SIZE) ?
                                 (IFM_W - KERNEL_SIZE) : FIFO_SIZE;

    localparam logic [CNT_WIDTH-1:0] LP_ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] LP_COL_LAST  = CNT_WIDTH'(IFM_W - 1);
    localparam logic [CNT_WIDTH-1:0] LP_ROW_LAST  = CNT_WIDTH'(IFM_H - 1);
    localparam logic [CNT_WIDTH-1:0] LP_FILL      = CNT_WIDTH'(KERNEL_SIZE);
    localparam logic [CNT_WIDTH-1:0] LP_RD_THR    = CNT_WIDTH'(LP_RD_THR_I);
    localparam logic [CNT_WIDTH-1:0] LP_WIN_FIRST = CNT_WIDTH'(KERNEL_SIZE - 1);

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [CNT_WIDTH-1:0] r_col;      // input raster position
    logic [CNT_WIDTH-1:0] r_row;
    logic [CNT_WIDTH-1:0] r_ocol;     // position of the pixel leaving FIFO 2
    logic [CNT_WIDTH-1:0] r_orow;
    logic [CNT_WIDTH-1:0] r_adv_cnt;  // advances since CLEAR, saturates at LP_FILL
    logic [CNT_WIDTH-1:0] r_wr_cnt;   // writes per FIFO, saturates at LP_RD_THR
    logic                 r_acc_d;    // accept delayed by one cycle

    logic w_accept;
    logic w_set_reg;
    logic w_wr;
    logic w_rd01;
    logic w_rd2;
    logic w_last_in;
    logic w_last_out;

    assign w_accept  = (r_state == S_STREAM) && ifm_valid;
    // DRAIN keeps the array stepping after the input has ended. In the first
    // DRAIN cycle, this term overlaps the delayed final accept and produces
    // only one advance.
    assign w_set_reg = r_acc_d || (r_state == S_DRAIN);
    // The row pipeline is full once KERNEL_SIZE pixels have moved through it.
    assign w_wr      = w_set_reg && (r_adv_cnt == LP_FILL);
    // All FIFOs are written together, so one write counter serves all three.
    assign w_rd01    = w_wr && (r_wr_cnt == LP_RD_THR);
    assign w_rd2     = w_set_reg && (r_wr_cnt != '0);

    assign w_last_in  = w_accept && (r_col == LP_COL_LAST) && (r_row == LP_ROW_LAST);
    assign w_last_out = w_rd2 && (r_ocol == LP_COL_LAST) && (r_orow == LP_ROW_LAST);

    always_comb begin
        // NOTE: the default comes first so that no path leaves the signal unassigned, which would infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (start) w_state_nxt = S_CLEAR;
            S_CLEAR:    w_state_nxt = S_LOAD_WGT;
            S_LOAD_WGT: w_state_nxt = S_STREAM;
            S_STREAM:   if (w_last_in) w_state_nxt = S_DRAIN;
            S_DRAIN:    if (w_last_out) w_state_nxt = S_DONE;
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_ocol    <= '0;
            r_orow    <= '0;
            r_adv_cnt <= '0;
            r_wr_cnt  <= '0;
            r_acc_d   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc_d <= w_accept;
            if (r_state == S_CLEAR) begin
                r_col     <= '0;
                r_row     <= '0;
                r_ocol    <= '0;
                r_orow    <= '0;
                r_adv_cnt <= '0;
                r_wr_cnt  <= '0;
            end else begin
                if (w_accept) begin
                    if (r_col == LP_COL_LAST) begin
                        r_col <= '0;
                        r_row <= (r_row == LP_ROW_LAST) ? '0 : r_row + LP_ONE;
                    end else begin
                        r_col <= r_col + LP_ONE;
                    end
                end
                if (w_set_reg && (r_adv_cnt != LP_FILL)) r_adv_cnt <= r_adv_cnt + LP_ONE;
                if (w_wr && (r_wr_cnt != LP_RD_THR))     r_wr_cnt  <= r_wr_cnt + LP_ONE;
                if (w_rd2) begin
                    if (r_ocol == LP_COL_LAST) begin
                        r_ocol <= '0;
                        r_orow <= (r_orow == LP_ROW_LAST) ? '0 : r_orow + LP_ONE;
                    end else begin
                        r_ocol <= r_ocol + LP_ONE;
                    end
                end
            end
        end
    end

    assign ifm_ready = (r_state == S_STREAM);
    assign set_wgt   = (r_state == S_LOAD_WGT);
    assign rd_clr    = (r_state == S_CLEAR);
    assign wr_clr    = (r_state == S_CLEAR);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign set_ifm   = w_accept;
    assign set_reg   = w_set_reg;
    assign wr_en     = {3{w_wr}};
    assign rd_en     = {w_rd2, w_rd01, w_rd01};
    // Only full kernel windows (bottom-right corner at or beyond K-1, K-1)
    // produce a result.
    assign out_valid = w_rd2 && (r_orow >= LP_WIN_FIRST) && (r_ocol >= LP_WIN_FIRST);

`ifdef CONV_CTRL_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk1) begin
        if (rst || (r_state == S_CLEAR)) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_STREAM) && !ifm_valid && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_ctrl.sv
`timescale 1ns/1ps

module tb_conv_ctrl;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int K    = 3;
    localparam int NPIX = W * H;
    localparam int NOUT = (H - K + 1) * (W - K + 1);

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ifm_valid = 1'b0;
    logic        ifm_ready, set_wgt, set_ifm, set_reg, rd_clr, wr_clr;
    logic        out_valid, busy, done;
    logic [2:0]  wr_en, rd_en;
    logic [15:0] stall_cnt;

    // Second instance with a small 4x3 map.
    logic        start_s = 1'b0;
    logic        valid_s = 1'b0;
    logic        ready_s, set_wgt_s, set_ifm_s, set_reg_s, rd_clr_s, wr_clr_s;
    logic        out_valid_s, busy_s, done_s;
    logic [2:0]  wr_en_s, rd_en_s;
    logic [15:0] stall_cnt_s;

    conv_ctrl #(.IFM_W(W), .IFM_H(H), .KERNEL_SIZE(K), .FIFO_SIZE(7), .CNT_WIDTH(8)) u_dut (
        .clk1(clk1), .rst(rst), .start(start), .ifm_valid(ifm_valid),
        .ifm_ready(ifm_ready), .set_wgt(set_wgt), .set_ifm(set_ifm), .set_reg(set_reg),
        .wr_en(wr_en), .rd_en(rd_en), .rd_clr(rd_clr), .wr_clr(wr_clr),
        .out_valid(out_valid), .busy(busy), .done(done), .stall_cnt(stall_cnt)
    );

    conv_ctrl #(.IFM_W(4), .IFM_H(3), .KERNEL_SIZE(3), .FIFO_SIZE(7), .CNT_WIDTH(8)) u_dut_s (
        .clk1(clk1), .rst(rst), .start(start_s), .ifm_valid(valid_s),
        .ifm_ready(ready_s), .set_wgt(set_wgt_s), .set_ifm(set_ifm_s), .set_reg(set_reg_s),
        .wr_en(wr_en_s), .rd_en(rd_en_s), .rd_clr(rd_clr_s), .wr_clr(wr_clr_s),
        .out_valid(out_valid_s), .busy(busy_s), .done(done_s), .stall_cnt(stall_cnt_s)
    );

    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    logic [30:0] all_outs;
    assign all_outs = {ifm_ready, set_wgt, set_ifm, set_reg, wr_en, rd_en, rd_clr, wr_clr,
                       out_valid, busy, done, stall_cnt};

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the j-th PE advance (1-based) in a frame.
    // The row pipeline fills after K advances, so writes start at j = K+1.
    // FIFOs 0/1 are read once they hold W-K entries, and FIFO 2 once it holds one.
    // The FIFO-2 read index runs over the raster, and a result is valid
    // whenever that raster pixel completes a full KxK window.
    function automatic logic [6:0] model_ctl(input int j);
        logic wr, rd01, rd2, ov;
        int   idx;
        wr   = (j > K);
        rd01 = (j > W);
        rd2  = (j >= K + 2);
        idx  = j - (K + 2);
        ov   = rd2 && ((idx / W) >= K - 1) && ((idx % W) >= K - 1);
        return {{3{wr}}, rd2, rd01, rd01, ov};
    endfunction

    typedef struct {
        int         cyc;
        logic [6:0] ctl;
    } rec_t;

    rec_t sb[$];
    rec_t mon_r;
    int   ov_cnt, done_cnt, occ, occ_max;

    // Monitor: pops one expected record per observed set_reg.
    always @(negedge clk1) begin
        if (rst) begin
            occ = 0;
        end else begin
            if (set_reg) begin
                if (sb.size() == 0) begin
                    check("sreg_unexpected", 64'(set_reg), 64'(0));
                end else begin
                    mon_r = sb.pop_front();
                    check("sreg_cycle", 64'(cyc), 64'(mon_r.cyc));
                    check("sreg_ctl", 64'({wr_en, rd_en, out_valid}), 64'(mon_r.ctl));
                end
            end else begin
                check("strobe_without_sreg", 64'({wr_en, rd_en, out_valid}), 64'(0));
            end
            if (rd_clr) occ = 0;
            occ = occ + int'(wr_en[0]) - int'(rd_en[0]);
            if (occ > occ_max) occ_max = occ;
            ov_cnt   += int'(out_valid);
            done_cnt += int'(done);
        end
    end

    int ov_s_cnt, done_s_cnt, wr_s_total, wr_before_rd;
    bit first_rd_pending;

    always @(negedge clk1) begin
        if (!rst) begin
            ov_s_cnt   += int'(out_valid_s);
            done_s_cnt += int'(done_s);
            if (rd_en_s[0] && first_rd_pending) begin
                wr_before_rd     = wr_s_total;
                first_rd_pending = 1'b0;
            end
            wr_s_total += int'(wr_en_s[0]);
        end
    end

    task automatic run_frame(input bit stall_mode, input bit poke, input int abort_at);
        int pix, k, t0, c_last, stalls, dcyc, exp_stall;
        bit got;
        pix = 0; k = 0; stalls = 0; c_last = 0; dcyc = -1; got = 1'b0;
        ov_cnt = 0; done_cnt = 0; occ_max = 0;
        @(posedge clk1); #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk1); #1;
        start = 1'b0;
        @(negedge clk1);
        check("clr_at_t1", 64'({rd_clr, wr_clr, busy, set_wgt}), 64'(4'b1110));
        check("t1_cycle", 64'(cyc), 64'(t0 + 1));
        @(posedge clk1); #1;
        @(negedge clk1);
        check("wgt_at_t2", 64'({set_wgt, ifm_ready, rd_clr}), 64'(3'b100));
        @(posedge clk1); #1;
        while (pix < NPIX) begin
            if (pix == abort_at) begin
                ifm_valid = 1'b0;
                rst = 1'b1;
                sb.delete();
                @(posedge clk1); #1;
                rst = 1'b0;
                @(negedge clk1);
                check("abort_outputs_zero", 64'(all_outs), 64'(0));
                return;
            end
            ifm_valid = !(stall_mode && (k % 3 == 2));
            k++;
            start = poke && (pix == 20);
            @(negedge clk1);
            check("ready_in_stream", 64'(ifm_ready), 64'(1));
            check("set_ifm", 64'(set_ifm), 64'(ifm_valid));
            if (ifm_valid) begin
                pix++;
                sb.push_back('{cyc + 1, model_ctl(pix)});
                if (pix == NPIX) c_last = cyc;
            end else begin
                stalls++;
            end
            @(posedge clk1); #1;
        end
        ifm_valid = 1'b0;
        start = 1'b0;
        for (int j = 1; j <= K + 1; j++) sb.push_back('{c_last + 1 + j, model_ctl(NPIX + j)});
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk1);
            if (done) begin
                got = 1'b1;
                dcyc = cyc;
            end
        end
        check("done_seen", 64'(got), 64'(1));
        check("done_cycle", 64'(dcyc), 64'(c_last + K + 3));
        @(negedge clk1);
        check("idle_after_done", 64'({busy, done, ifm_ready}), 64'(0));
`ifdef CONV_CTRL_STALL_CNT_EN
        exp_stall = stalls;
`else
        exp_stall = 0;
`endif
        check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        check("out_valid_count", 64'(ov_cnt), 64'(NOUT));
        check("done_count", 64'(done_cnt), 64'(1));
        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        check("fifo01_max_occupancy", 64'(occ_max), 64'(W - K));
    endtask

    task automatic run_small();
        bit got;
        got = 1'b0;
        ov_s_cnt = 0; done_s_cnt = 0; wr_s_total = 0; wr_before_rd = -1;
        first_rd_pending = 1'b1;
        @(posedge clk1); #1;
        start_s = 1'b1;
        @(posedge clk1); #1;
        start_s = 1'b0;
        @(posedge clk1); #1;
        @(posedge clk1); #1;
        valid_s = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk1);
            check("small_ready", 64'(ready_s), 64'(1));
            @(posedge clk1); #1;
        end
        valid_s = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk1);
            if (done_s) got = 1'b1;
        end
        check("small_done_seen", 64'(got), 64'(1));
        @(negedge clk1);
        check("small_out_valid_count", 64'(ov_s_cnt), 64'(2));
        check("small_done_count", 64'(done_s_cnt), 64'(1));
        check("small_writes_before_first_read", 64'(wr_before_rd), 64'(1));
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk1);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk1);
            check("idle_outputs_zero", 64'(all_outs), 64'(0));
        end
        run_frame(1'b0, 1'b0, -1);   // continuous stream
        run_frame(1'b1, 1'b0, -1);   // valid low every third cycle
        run_frame(1'b0, 1'b1, -1);   // start re-pulsed mid-stream
        run_frame(1'b1, 1'b0, 30);   // reset at pixel 30
        run_frame(1'b0, 1'b0, -1);   // clean frame after the abort
        run_small();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
